jtag_scan_master: RTL and testbench

// - Synthesizable JTAG TAP bit-bang master. Runs one IR scan or one DR scan per request on jtag_TCK/TMS/TDI and captures jtag_TDO.
// - Replaces hand-coded TMS/TDI sequences. Drives the SoC's jtag_top from an on-chip or bench stimulus source.
// - Parametrised in IR length, DR length, TCK rate and idle padding.

---
 rtl/jtag_scan_master.sv | 206 ++++++++++++++++++++
 tb/tb_jtag_scan_master.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_scan_master.sv
// rtl/jtag_scan_master.sv - JTAG TAP bit-bang master running one IR or DR scan per request
//
// Purpose: drives jtag_TCK/TMS/TDI from a valid/ready request and returns the
// captured jtag_TDO bits as a one-cycle response. After reset it walks the TAP
// through Test-Logic-Reset into Run-Test/Idle before accepting requests.
//
// Optional feature: JTAG_SCAN_PAUSE_EN routes Exit1 -> Pause -> Exit2 -> Update
// instead of Exit1 -> Update.
//
// Ports:
//   clk, rst          system clock, synchronous active-low reset
//   req_valid_i/req_ready_o, req_is_ir_i, req_len_i, req_data_i   scan request
//   rsp_valid_o, rsp_err_o, rsp_data_o                            scan response
//   busy_o            TAP reset sequence or scan in progress
//   jtag_TCK/TMS/TDI  JTAG outputs, jtag_TDO JTAG input
module jtag_scan_master #(
   parameter int IR_LEN      = 5,
   parameter int DR_MAX      = 40,
   parameter int LEN_W       = 6,
   parameter int TCK_DIV     = 4,
   parameter int IDLE_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_is_ir_i,
   input  logic [LEN_W-1:0]  req_len_i,
   input  logic [DR_MAX-1:0] req_data_i,
   output logic              rsp_valid_o,
   output logic              rsp_err_o,
   output logic [DR_MAX-1:0] rsp_data_o,
   output logic              busy_o,
   output logic              jtag_TCK,
   output logic              jtag_TMS,
   output logic              jtag_TDI,
   input  logic              jtag_TDO
);

   localparam int CNT_W = (LEN_W > 4) ? LEN_W : 4;
   localparam int IDX_W = (DR_MAX > 1) ? $clog2(DR_MAX) : 1;
   localparam int DIV_W = (TCK_DIV > 1) ? $clog2(2 * TCK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(TCK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * TCK_DIV - 1);

   typedef enum logic [3:0] {
      S_TLR, S_IDLE, S_CHECK, S_SEL_DR, S_SEL_IR, S_CAPTURE,
      S_SHIFT_ENTRY, S_SHIFT, S_PAUSE, S_EXIT2, S_UPDATE, S_RTI
   } state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [DIV_W-1:0]  r_div;
   logic              r_tck, r_tms, r_tdi;
   logic              r_is_ir;
   logic [LEN_W-1:0]  r_len;
   logic [DR_MAX-1:0] r_data, r_cap;
   logic              r_rsp_valid, r_rsp_err, r_busy;
   logic [DR_MAX-1:0] r_rsp_data;

   state_t            w_state_nxt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic [CNT_W-1:0]  w_n_m1;
   logic              w_step_end, w_stepping, w_accept;
   logic              w_rsp, w_err, w_tms_nxt, w_tdi_nxt;

   assign w_step_end = (r_div == DIV_LAST);
   assign w_stepping = (r_state != S_IDLE) && (r_state != S_CHECK);
   assign w_accept   = (r_state == S_IDLE) && req_valid_i;
   assign w_n_m1     = CNT_W'(r_len) - CNT_W'(1);

   // Next state plus the TMS/TDI level for whichever step starts next.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_rsp       = 1'b0;
      w_err       = 1'b0;
      case (r_state)
         S_IDLE: if (req_valid_i) w_state_nxt = S_CHECK;
         S_CHECK: begin
            if (!r_is_ir && (r_len == '0 || r_len > LEN_W'(DR_MAX))) begin
               w_state_nxt = S_IDLE;
               w_rsp       = 1'b1;
               w_err       = 1'b1;
            end else begin
               w_state_nxt = S_SEL_DR;
               w_cnt_nxt   = '0;
            end
         end
         default: begin
            if (w_step_end) begin
               case (r_state)
                  S_TLR: begin
                     if (r_cnt == CNT_W'(8)) w_state_nxt = S_IDLE;
                     else                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                  end
                  S_SEL_DR:      w_state_nxt = r_is_ir ? S_SEL_IR : S_CAPTURE;
                  S_SEL_IR:      w_state_nxt = S_CAPTURE;
                  S_CAPTURE:     w_state_nxt = S_SHIFT_ENTRY;
                  S_SHIFT_ENTRY: begin
                     w_state_nxt = S_SHIFT;
                     w_cnt_nxt   = '0;
                  end
                  S_SHIFT: begin
                     if (r_cnt == w_n_m1) begin
`ifdef JTAG_SCAN_PAUSE_EN
                        w_state_nxt = S_PAUSE;
`else
                        w_state_nxt = S_UPDATE;
`endif
                     end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                     end
                  end
                  S_PAUSE:  w_state_nxt = S_EXIT2;
                  S_EXIT2:  w_state_nxt = S_UPDATE;
                  S_UPDATE: begin
                     w_cnt_nxt = '0;
                     if (IDLE_CYCLES == 0) begin
                        w_state_nxt = S_IDLE;
                        w_rsp       = 1'b1;
                     end else begin
                        w_state_nxt = S_RTI;
                     end
                  end
                  S_RTI: begin
                     if (r_cnt == CNT_W'(IDLE_CYCLES - 1)) begin
                        w_state_nxt = S_IDLE;
                        w_rsp       = 1'b1;
                     end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                     end
                  end
                  default: w_state_nxt = r_state;
               endcase
            end
         end
      endcase

      case (w_state_nxt)
         S_TLR:                                 w_tms_nxt = (w_cnt_nxt < CNT_W'(8));
         S_SEL_DR, S_SEL_IR, S_EXIT2, S_UPDATE: w_tms_nxt = 1'b1;
         S_SHIFT:                               w_tms_nxt = (w_cnt_nxt == w_n_m1);
         default:                               w_tms_nxt = 1'b0;
      endcase
      w_tdi_nxt = (w_state_nxt == S_SHIFT) ? r_data[w_cnt_nxt[IDX_W-1:0]] : 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= S_TLR;
         r_cnt       <= '0;
         r_div       <= '0;
         r_tck       <= 1'b0;
         r_tms       <= 1'b1;
         r_tdi       <= 1'b1;
         r_is_ir     <= 1'b0;
         r_len       <= '0;
         r_data      <= '0;
         r_cap       <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_data  <= '0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_rsp_valid <= w_rsp;
         r_busy      <= (w_state_nxt != S_IDLE);
         if (w_rsp) begin
            r_rsp_err  <= w_err;
            r_rsp_data <= w_err ? '0 : r_cap;
         end
         if (w_accept) begin
            r_is_ir <= req_is_ir_i;
            r_len   <= req_is_ir_i ? LEN_W'(IR_LEN) : req_len_i;
            r_data  <= req_data_i;
            r_cap   <= '0;
         end
         // Each step: TMS/TDI change with TCK falling, TDO sampled on the
         // clk that raises TCK (end of the low half).
         if (w_stepping && !w_step_end) begin
            r_div <= r_div + DIV_W'(1);
            if (r_div == DIV_RISE) begin
               r_tck <= 1'b1;
               if (r_state == S_SHIFT) r_cap[r_cnt[IDX_W-1:0]] <= jtag_TDO;
            end
         end else begin
            r_div <= '0;
            r_tck <= 1'b0;
            r_tms <= w_tms_nxt;
            r_tdi <= w_tdi_nxt;
         end
      end
   end

   assign req_ready_o = (r_state == S_IDLE);
   assign rsp_valid_o = r_rsp_valid;
   assign rsp_err_o   = r_rsp_err;
   assign rsp_data_o  = r_rsp_data;
   assign busy_o      = r_busy;
   assign jtag_TCK    = r_tck;
   assign jtag_TMS    = r_tms;
   assign jtag_TDI    = r_tdi;

endmodule

// File: tb/tb_jtag_scan_master.sv
// tb/tb_jtag_scan_master.sv - directed bench for jtag_scan_master with a TAP model
module tb_jtag_scan_master;

`ifdef JTAG_SCAN_PAUSE_EN
   localparam int          P        = 2;
   localparam logic [63:0] IR_TMS   = 64'hD03;
   localparam int          IR_EDGES = 13;
`else
   localparam int          P        = 0;
   localparam logic [63:0] IR_TMS   = 64'h303;
   localparam int          IR_EDGES = 11;
`endif
   localparam logic [39:0] DR_PRELOAD = 40'hA5_1234_5678;
   localparam logic [39:0] DR_SEND    = 40'h40_0000_0002;

   localparam int T_TLR = 0, T_RTI = 1, T_SDR = 2, T_CDR = 3, T_SHDR = 4, T_E1DR = 5,
                  T_PDR = 6, T_E2DR = 7, T_UDR = 8, T_SIR = 9, T_CIR = 10, T_SHIR = 11,
                  T_E1IR = 12, T_PIR = 13, T_E2IR = 14, T_UIR = 15;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   logic        valid0, is_ir0, ready0, rsp_valid0, rsp_err0, busy0, tck0, tms0, tdi0, tdo0;
   logic [5:0]  len0;
   logic [39:0] data0, rsp_data0;
   logic        valid1, is_ir1, ready1, rsp_valid1, rsp_err1, busy1, tck1, tms1, tdi1;
   logic [5:0]  len1;
   logic [39:0] data1, rsp_data1;

   jtag_scan_master u_dut0 (
      .clk(clk), .rst(rst), .req_valid_i(valid0), .req_ready_o(ready0), .req_is_ir_i(is_ir0),
      .req_len_i(len0), .req_data_i(data0), .rsp_valid_o(rsp_valid0), .rsp_err_o(rsp_err0),
      .rsp_data_o(rsp_data0), .busy_o(busy0), .jtag_TCK(tck0), .jtag_TMS(tms0),
      .jtag_TDI(tdi0), .jtag_TDO(tdo0));

   // Second instance at TCK_DIV=1 with TDO looped back to TDI.
   jtag_scan_master #(.TCK_DIV(1)) u_dut1 (
      .clk(clk), .rst(rst), .req_valid_i(valid1), .req_ready_o(ready1), .req_is_ir_i(is_ir1),
      .req_len_i(len1), .req_data_i(data1), .rsp_valid_o(rsp_valid1), .rsp_err_o(rsp_err1),
      .rsp_data_o(rsp_data1), .busy_o(busy1), .jtag_TCK(tck1), .jtag_TMS(tms1),
      .jtag_TDI(tdi1), .jtag_TDO(tdi1));

   // TAP model for dut0
   int          tap = T_TLR;
   logic        tms_q[$];
   logic        shtdi_q[$];
   logic [39:0] dr_sh = '0, dr_upd = '0;
   logic [4:0]  ir_sh = '0, ir_upd = '0;
   assign tdo0 = (tap == T_SHIR) ? 1'b1 : dr_sh[0];

   function automatic int tap_next(input int s, input logic m);
      case (s)
         T_TLR:  return m ? T_TLR  : T_RTI;
         T_RTI:  return m ? T_SDR  : T_RTI;
         T_SDR:  return m ? T_SIR  : T_CDR;
         T_CDR:  return m ? T_E1DR : T_SHDR;
         T_SHDR: return m ? T_E1DR : T_SHDR;
         T_E1DR: return m ? T_UDR  : T_PDR;
         T_PDR:  return m ? T_E2DR : T_PDR;
         T_E2DR: return m ? T_UDR  : T_SHDR;
         T_UDR:  return m ? T_SDR  : T_RTI;
         T_SIR:  return m ? T_TLR  : T_CIR;
         T_CIR:  return m ? T_E1IR : T_SHIR;
         T_SHIR: return m ? T_E1IR : T_SHIR;
         T_E1IR: return m ? T_UIR  : T_PIR;
         T_PIR:  return m ? T_E2IR : T_PIR;
         T_E2IR: return m ? T_UIR  : T_SHIR;
         default: return m ? T_SDR : T_RTI;
      endcase
   endfunction

   always @(posedge tck0) begin
      tms_q.push_back(tms0);
      case (tap)
         T_CDR:  dr_sh = DR_PRELOAD;
         T_CIR:  ir_sh = 5'b00001;
         T_SHDR: begin shtdi_q.push_back(tdi0); dr_sh = {tdi0, dr_sh[39:1]}; end
         T_SHIR: begin shtdi_q.push_back(tdi0); ir_sh = {tdi0, ir_sh[4:1]}; end
         T_UDR:  dr_upd = dr_sh;
         T_UIR:  ir_upd = ir_sh;
         default: ;
      endcase
      tap = tap_next(tap, tms0);
   end

   int tck1_edges = 0, tms1_ones = 0;
   always @(posedge tck1) begin
      tck1_edges = tck1_edges + 1;
      tms1_ones  = tms1_ones + int'(tms1);
   end

   int          rcyc0[$], rcyc1[$];
   logic [39:0] rdat0[$], rdat1[$];
   logic        rerr0[$], rerr1[$];
   always @(negedge clk) begin
      if (rsp_valid0 === 1'b1) begin rcyc0.push_back(cyc); rdat0.push_back(rsp_data0); rerr0.push_back(rsp_err0); end
      if (rsp_valid1 === 1'b1) begin rcyc1.push_back(cyc); rdat1.push_back(rsp_data1); rerr1.push_back(rsp_err1); end
   end

   function automatic logic [63:0] pack_tms(input int base);
      logic [63:0] v = '0;
      for (int i = base; i < tms_q.size() && i - base < 64; i++) v[i-base] = tms_q[i];
      return v;
   endfunction

   function automatic logic [63:0] pack_tdi(input int base);
      logic [63:0] v = '0;
      for (int i = base; i < shtdi_q.size() && i - base < 64; i++) v[i-base] = shtdi_q[i];
      return v;
   endfunction

   function automatic int rsp_count(input int sel);
      return (sel == 0) ? rcyc0.size() : rcyc1.size();
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input int sel, input logic ir, input logic [5:0] len, input logic [39:0] d,
                       input logic keep, output int acc);
      acc = -1;
      @(negedge clk);
      if (sel == 0) begin is_ir0 = ir; len0 = len; data0 = d; valid0 = 1'b1; end
      else          begin is_ir1 = ir; len1 = len; data1 = d; valid1 = 1'b1; end
      for (int i = 0; i < 3000; i++) begin
         if (((sel == 0) ? ready0 : ready1) === 1'b1) begin
            @(posedge clk);
            #1;
            acc = cyc;
            break;
         end
         @(negedge clk);
      end
      if (!keep) begin
         if (sel == 0) valid0 = 1'b0; else valid1 = 1'b0;
      end
      chk("accept_seen", 64'(acc >= 0), 64'd1);
   endtask

   task automatic wait_rsp(input int sel, input int target);
      int n = 0;
      while (rsp_count(sel) < target && n < 3000) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("rsp_seen", 64'(rsp_count(sel) >= target), 64'd1);
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!(ready0 === 1'b1 && ready1 === 1'b1) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("ready_seen", 64'(ready0 === 1'b1 && ready1 === 1'b1), 64'd1);
   endtask

   initial begin
      int acc, acc2, tb, sb, rb, e0, t1b, m1b;
      rst = 1'b0;
      valid0 = 1'b0; is_ir0 = 1'b0; len0 = '0; data0 = '0;
      valid1 = 1'b0; is_ir1 = 1'b0; len1 = '0; data1 = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tck", 64'(tck0), 64'd0);
      chk("rst_tms", 64'(tms0), 64'd1);
      chk("rst_tdi", 64'(tdi0), 64'd1);
      chk("rst_ready", 64'(ready0), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid0), 64'd0);
      chk("rst_rsp_err", 64'(rsp_err0), 64'd0);
      chk("rst_rsp_data", 64'(rsp_data0), 64'd0);
      chk("rst_busy", 64'(busy0), 64'd0);

      // TAP reset sequence
      tb = tms_q.size();
      @(negedge clk);
      rst = 1'b1;
      wait_ready();
      chk("tlr_edges", 64'(tms_q.size() - tb), 64'd9);
      chk("tlr_tms", pack_tms(tb), 64'h0FF);
      chk("tlr_busy", 64'(busy0), 64'd0);
      chk("tlr_tap_rti", 64'(tap), 64'(T_RTI));

      // IR scan
      tb = tms_q.size(); sb = shtdi_q.size();
      send(0, 1'b1, 6'd0, 40'h11, 1'b0, acc);
      wait_rsp(0, 1);
      chk("ir_latency", 64'(rcyc0[0] - acc), 64'((11 + P) * 8 + 1));
      chk("ir_edges", 64'(tms_q.size() - tb), 64'(IR_EDGES));
      chk("ir_tms", pack_tms(tb), IR_TMS);
      chk("ir_tdi", pack_tdi(sb), 64'h11);
      chk("ir_update", 64'(ir_upd), 64'h11);
      chk("ir_data", 64'(rdat0[0]), 64'h1F);
      chk("ir_err", 64'(rerr0[0]), 64'd0);

      // DR scan, 40 bits
      send(0, 1'b0, 6'd40, DR_SEND, 1'b0, acc);
      wait_rsp(0, 2);
      chk("dr_latency", 64'(rcyc0[1] - acc), 64'((45 + P) * 8 + 1));
      chk("dr_data", 64'(rdat0[1]), 64'(DR_PRELOAD));
      chk("dr_err", 64'(rerr0[1]), 64'd0);
      chk("dr_update", 64'(dr_upd), 64'(DR_SEND));

      // Illegal lengths: 0 and DR_MAX+1
      for (int k = 0; k < 2; k++) begin
         e0 = tms_q.size();
         send(0, 1'b0, (k == 0) ? 6'd0 : 6'd41, 40'hFF_FFFF_FFFF, 1'b0, acc);
         wait_rsp(0, 3 + k);
         chk("bad_latency", 64'(rcyc0[2+k] - acc), 64'd1);
         chk("bad_err", 64'(rerr0[2+k]), 64'd1);
         chk("bad_data", 64'(rdat0[2+k]), 64'd0);
         repeat (20) @(negedge clk);
         chk("bad_tck_edges", 64'(tms_q.size() - e0), 64'd0);
      end

      // Reset in the middle of shift step 20
      rb = rsp_count(0);
      sb = shtdi_q.size();
      send(0, 1'b0, 6'd40, DR_SEND, 1'b0, acc);
      for (int i = 0; i < 3000 && (shtdi_q.size() - sb) < 20; i++) @(negedge clk);
      chk("mid_reached", 64'(shtdi_q.size() - sb), 64'd20);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("mid_tck", 64'(tck0), 64'd0);
      chk("mid_tms", 64'(tms0), 64'd1);
      chk("mid_tdi", 64'(tdi0), 64'd1);
      chk("mid_ready", 64'(ready0), 64'd0);
      chk("mid_busy", 64'(busy0), 64'd0);
      chk("mid_rsp_valid", 64'(rsp_valid0), 64'd0);
      chk("mid_rsp_err", 64'(rsp_err0), 64'd0);
      tb = tms_q.size(); t1b = tck1_edges; m1b = tms1_ones;
      @(negedge clk);
      rst = 1'b1;
      wait_ready();
      chk("mid_tlr_edges", 64'(tms_q.size() - tb), 64'd9);
      chk("mid_tlr_tms", pack_tms(tb), 64'h0FF);
      chk("dut1_tlr_edges", 64'(tck1_edges - t1b), 64'd9);
      chk("dut1_tlr_tms_ones", 64'(tms1_ones - m1b), 64'd8);
      chk("dut1_busy", 64'(busy1), 64'd0);
      repeat (400) @(negedge clk);
      chk("mid_no_rsp", 64'(rsp_count(0)), 64'(rb));

      // Back-to-back on dut0 (TCK_DIV=4)
      send(0, 1'b0, 6'd8, 40'h5A, 1'b1, acc);
      send(0, 1'b0, 6'd3, 40'h6, 1'b0, acc2);
      wait_rsp(0, rb + 2);
      chk("b2b0_lat1", 64'(rcyc0[rb] - acc), 64'((13 + P) * 8 + 1));
      chk("b2b0_lat2", 64'(rcyc0[rb+1] - acc2), 64'((8 + P) * 8 + 1));
      chk("b2b0_order", 64'(acc2 > rcyc0[rb]), 64'd1);

      // Back-to-back on dut1 (TCK_DIV=1, TDO = TDI loopback)
      send(1, 1'b0, 6'd8, 40'hFF_FFFF_FFA5, 1'b1, acc);
      send(1, 1'b1, 6'd9, 40'h1F3, 1'b0, acc2);
      wait_rsp(1, 2);
      chk("b2b1_lat1", 64'(rcyc1[0] - acc), 64'((13 + P) * 2 + 1));
      chk("b2b1_lat2", 64'(rcyc1[1] - acc2), 64'((11 + P) * 2 + 1));
      chk("b2b1_order", 64'(acc2 > rcyc1[0]), 64'd1);
      chk("b2b1_data1", 64'(rdat1[0]), 64'hA5);
      chk("b2b1_data2", 64'(rdat1[1]), 64'h13);
      chk("b2b1_err", 64'({rerr1[0], rerr1[1]}), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
